coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor_pkg.sv | 18 +
 rtl/coin_acceptor_fifo.sv | 57 +++++
 rtl/coin_acceptor.sv | 171 +++++++++++++++++
 tb/tb_coin_acceptor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/coin_acceptor_pkg.sv
// Shared types and constants for the coin acceptor: debouncer state
// encoding and the denomination codes carried through the coin FIFO.
package coin_acceptor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } deb_state_t;

  localparam logic COIN_5  = 1'b0;
  localparam logic COIN_10 = 1'b1;

  // Debounce counter is sized for the largest legal DEBOUNCE_CYCLES (15).
  localparam int DEB_CNT_W = 4;

endpackage

// File: rtl/coin_acceptor_fifo.sv
// coin_fifo: small circular queue of confirmed coins. Pointers wrap
// naturally because DEPTH is a power of two. Push is ignored when full and
// pop when empty, so the count never leaves 0..DEPTH.
module coin_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wr;
  logic [AW-1:0]           r_rd;
  logic [CW-1:0]           r_count;
  logic                    w_push;
  logic                    w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count as is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces the coin slot sensor, queues
// confirmed coins and issues spaced in5/in10 pulses to the vending stage.
// Optional build macro COIN_ACCEPTOR_STATS_EN adds delivered/returned
// coin counters (total5, total10, total_ret).
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         coin_sense,
  input  logic                         coin_type,
  input  logic                         refuse,
  output logic                         in5,
  output logic                         in10,
  output logic                         coin_return,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  output logic [15:0]                  total5,
  output logic [15:0]                  total10,
  output logic [15:0]                  total_ret
`endif
);
  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           r_sense_sync;
  logic [1:0]           r_type_sync;
  deb_state_t           r_state;
  deb_state_t           w_state_nxt;
  logic [DEB_CNT_W-1:0] r_cnt;
  logic [DEB_CNT_W-1:0] w_cnt_nxt;
  logic                 w_sense;
  logic                 w_evt;
  logic                 r_evt;
  logic                 r_evt_type;
  logic                 r_in5;
  logic                 r_in10;
  logic                 r_ret;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_head;
  logic                 w_push;
  logic                 w_pop;

  assign w_sense = r_sense_sync[1];

  // Two-flop synchronisers on both raw sensor inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sense_sync <= '0;
      r_type_sync  <= '0;
    end else begin
      r_sense_sync <= {r_sense_sync[0], coin_sense};
      r_type_sync  <= {r_type_sync[0], coin_type};
    end
  end

  // Debouncer state and run-length counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Debouncer next state; the coin event fires only on CONFIRM->HELD.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_evt       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sense) w_state_nxt = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (!w_sense) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HELD;
          w_evt       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!w_sense) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (w_sense) begin
          w_state_nxt = ST_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Register the coin event with the denomination seen in the confirm cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt      <= 1'b0;
      r_evt_type <= COIN_5;
    end else begin
      r_evt <= w_evt;
      if (w_evt) r_evt_type <= r_type_sync[1];
    end
  end

  // Full is judged on the start-of-cycle count, so a same-cycle pop never
  // rescues an overflowing coin. A pulse in flight blocks the next pop,
  // guaranteeing at least one idle cycle between pulses.
  assign w_push = r_evt && !w_full;
  assign w_pop  = !w_empty && !refuse && !r_in5 && !r_in10;

  coin_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (1)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (r_evt_type),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Output pulses: delivery by denomination, or eject on overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in5  <= 1'b0;
      r_in10 <= 1'b0;
      r_ret  <= 1'b0;
    end else begin
      r_in5  <= w_pop && (w_head == COIN_5);
      r_in10 <= w_pop && (w_head == COIN_10);
      r_ret  <= r_evt && w_full;
    end
  end

  assign in5         = r_in5;
  assign in10        = r_in10;
  assign coin_return = r_ret;

`ifdef COIN_ACCEPTOR_STATS_EN
  // Free-running wrap-around counts of each output pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total5    <= '0;
      total10   <= '0;
      total_ret <= '0;
    end else begin
      total5    <= total5 + 16'(r_in5);
      total10   <= total10 + 16'(r_in10);
      total_ret <= total_ret + 16'(r_ret);
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios followed by a
// randomized phase, all compared every cycle against a queue-based model.
module tb_coin_acceptor;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n, coin_sense, coin_type, refuse;
  logic in5, in10, coin_return;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [15:0] total5, total10, total_ret;
`endif

  coin_acceptor #(
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .coin_sense  (coin_sense),
    .coin_type   (coin_type),
    .refuse      (refuse),
    .in5         (in5),
    .in10        (in10),
    .coin_return (coin_return),
    .fifo_count  (fifo_count)
`ifdef COIN_ACCEPTOR_STATS_EN
    ,
    .total5      (total5),
    .total10     (total10),
    .total_ret   (total_ret)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: coins waiting downstream, coins scheduled to reach the queue.
  bit mq[$];
  int arr_edge[$];
  bit arr_type[$];
  bit last_pulse;
  int m5, m10, mret;

  // Observations of the DUT (counted, never used as expectations).
  int o5, o10, oret;
  int last_pulse_edge;
  int pedge[$];
  bit ptype[$];

  bit rnd_on   = 1'b0;
  int rnd_pct  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    arr_edge.delete();
    arr_type.delete();
    last_pulse = 1'b0;
    m5 = 0; m10 = 0; mret = 0;
  endtask

  // One clock: advance the model using pre-edge inputs, then compare.
  task automatic step();
    bit r, ev, et, pop, full, h, e5, e10, eret;
    int edge_i;
    if (rnd_on) refuse = ($urandom_range(0, 99) < rnd_pct);
    r = refuse;
    @(posedge clk);
    edge_i = cyc;
    cyc++;
    e5 = 1'b0; e10 = 1'b0; eret = 1'b0;
    if (!reset_n) begin
      model_clear();
    end else begin
      ev = 1'b0; et = 1'b0;
      if (arr_edge.size() > 0 && arr_edge[0] == edge_i) begin
        ev = 1'b1;
        et = arr_type.pop_front();
        void'(arr_edge.pop_front());
      end
      full = (mq.size() >= DEPTH);
      pop  = (mq.size() > 0) && !r && !last_pulse;
      if (pop) begin
        h   = mq.pop_front();
        e5  = (h == 1'b0);
        e10 = (h == 1'b1);
      end
      eret = ev && full;
      if (ev && !full) mq.push_back(et);
      last_pulse = e5 | e10;
      m5 += int'(e5); m10 += int'(e10); mret += int'(eret);
    end
    #1;
    chk("in5", 32'(in5), 32'(e5));
    chk("in10", 32'(in10), 32'(e10));
    chk("coin_return", 32'(coin_return), 32'(eret));
    chk("fifo_count", 32'(fifo_count), mq.size());
    if (in5 === 1'b1) o5++;
    if (in10 === 1'b1) o10++;
    if (coin_return === 1'b1) oret++;
    if (in5 === 1'b1 || in10 === 1'b1) begin
      last_pulse_edge = edge_i;
      pedge.push_back(edge_i);
      ptype.push_back(in10 === 1'b1);
    end
  endtask

  // A clean coin: first sampled on the upcoming edge, reaches the queue
  // two synchroniser edges + D confirm samples + the event register later.
  task automatic coin(input bit t, input int hi, input int lo);
    coin_type  = t;
    coin_sense = 1'b1;
    arr_edge.push_back(cyc + 2 + D + 1);
    arr_type.push_back(t);
    repeat (hi) step();
    coin_sense = 1'b0;
    repeat (lo) step();
  endtask

  initial begin
    int e0, b5, b10, bret;
    reset_n = 1'b0; coin_sense = 1'b0; coin_type = 1'b0; refuse = 1'b0;
    model_clear();
    o5 = 0; o10 = 0; oret = 0; last_pulse_edge = -1;

    // Reset state
    repeat (3) step();
    chk("rst_count", 32'(fifo_count), 0);
    reset_n = 1'b1;
    repeat (4) step();

    // Single 5-coin: one in5 exactly 2+D+2 edges after first sample
    e0 = cyc; b5 = o5; bret = oret;
    coin(1'b0, 10, 14);
    chk("lat5", last_pulse_edge - e0, 2 + D + 2);
    chk("single5_n", o5 - b5, 1);
    chk("single5_ret", oret - bret, 0);

    // Bouncing sensor, then a clean 10-coin
    b5 = o5; b10 = o10;
    coin_type = 1'b1;
    repeat (3) begin
      coin_sense = 1'b1; repeat (2) step();
      coin_sense = 1'b0; step();
    end
    coin(1'b1, 10, 14);
    chk("bounce_n10", o10 - b10, 1);
    chk("bounce_n5", o5 - b5, 0);

    // Overflow with downstream busy
    refuse = 1'b1; bret = oret;
    for (int i = 0; i < 5; i++) coin(1'(i % 2), 8, 8);
    chk("ovf_count", 32'(fifo_count), DEPTH);
    chk("ovf_ret", oret - bret, 1);

    // Drain: pulses two edges apart in insertion order
    pedge.delete(); ptype.delete();
    refuse = 1'b0;
    repeat (12) step();
    chk("drain_n", pedge.size(), 4);
    for (int i = 0; i < 3 && i + 1 < pedge.size(); i++)
      chk("drain_gap", pedge[i+1] - pedge[i], 2);
    for (int i = 0; i < 4 && i < ptype.size(); i++)
      chk("drain_order", 32'(ptype[i]), 32'(i % 2));
    chk("drain_count", 32'(fifo_count), 0);

    // Reset mid-operation clears the queue asynchronously
    refuse = 1'b1;
    for (int i = 0; i < 3; i++) coin(1'b0, 8, 8);
    chk("pre_rst_count", 32'(fifo_count), 3);
    reset_n = 1'b0;
    #1;
    chk("async_count", 32'(fifo_count), 0);
    chk("async_in5", 32'(in5), 0);
    chk("async_in10", 32'(in10), 0);
    chk("async_ret", 32'(coin_return), 0);
    model_clear();
    step();
    reset_n = 1'b1;
    refuse = 1'b0;
    b5 = o5; b10 = o10;
    repeat (12) step();
    chk("post_rst_pulses", (o5 - b5) + (o10 - b10), 0);

    // Randomized coins with random backpressure
    rnd_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rnd_pct = (i % 3 == 0) ? 90 : $urandom_range(0, 60);
      coin(1'($urandom_range(0, 1)), $urandom_range(D + 2, D + 8),
           $urandom_range(D + 2, D + 10));
    end
    rnd_on = 1'b0;
    refuse = 1'b0;
    repeat (20) step();
    chk("final_count", 32'(fifo_count), 0);

`ifdef COIN_ACCEPTOR_STATS_EN
    chk("total5", 32'(total5), m5);
    chk("total10", 32'(total10), m10);
    chk("total_ret", 32'(total_ret), mret);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
